stim_driver: RTL and testbench

Parametrised successor to the operand driver in the arithmetic testbench. Drives random operands from the LFSRs into the DUT and periodically injects an all-zero "probe" operand pair. It measures DUT latency on every probe rather than once, and flags latency instability and timeouts. It also provides monitor-aligned copies of the operands actually driven, with a configurable delay depth.

---
 rtl/stim_driver_if.sv | 11 +
 rtl/stim_driver.sv | 102 ++++++++++
 tb/tb_stim_driver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/stim_driver_if.sv
// stim_driver_if: operand drive and DUT result bundle between the stimulus driver and the DUT
interface stim_driver_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] i_rand_a;
  logic [WIDTH-1:0] i_rand_b;
  logic [WIDTH-1:0] i_dut_out;
  logic [WIDTH-1:0] o_drive_a;
  logic [WIDTH-1:0] o_drive_b;
  logic             o_probe;
  modport master (input i_rand_a, i_rand_b, i_dut_out, output o_drive_a, o_drive_b, o_probe);
  modport slave (output i_rand_a, i_rand_b, i_dut_out, input o_drive_a, o_drive_b, o_probe);
endinterface

// File: rtl/stim_driver.sv
// stim_driver: random operand drive with periodic zero probes, latency measurement and monitor alignment
module stim_driver #(
  parameter int WIDTH       = 32,
  parameter int DELAY_DEPTH = 2,
  parameter int PERIOD_BITS = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic                 clk_dut,
  input  logic                 reset_n,
  input  logic                 i_probe_en,
  stim_driver_if.master        bus,
  output logic [WIDTH-1:0]     o_drive_delayed_a,
  output logic [WIDTH-1:0]     o_drive_delayed_b,
  output logic                 o_probe_delayed,
  output logic [CNT_WIDTH-1:0] o_dut_delay,
  output logic                 o_delay_valid,
  output logic                 o_delay_unstable,
  output logic                 o_timeout
);
  typedef enum logic [2:0] {FLUSH = 3'b001, ARMED = 3'b010, COUNT = 3'b100} state_t;
  localparam int DW = 2 * WIDTH + 1;
  state_t                 state_q, state_d;
  logic [PERIOD_BITS-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc, dut_delay_q, dut_delay_d, cap_v;
  logic                   valid_q, valid_d, unstable_q, unstable_d, timeout_q, timeout_d;
  logic                   cap, probe, dut_zero;
  logic [WIDTH-1:0]       drive_a, drive_b;
  logic [DW-1:0]          dly_q [DELAY_DEPTH];
  logic [DW-1:0]          dly_d [DELAY_DEPTH];
  assign probe    = (&period_q) & i_probe_en;
  assign drive_a  = probe ? '0 : bus.i_rand_a;
  assign drive_b  = probe ? '0 : bus.i_rand_b;
  assign bus.o_drive_a = drive_a;
  assign bus.o_drive_b = drive_b;
  assign bus.o_probe   = probe;
  assign period_d = period_q + 1'b1;
  assign dut_zero = bus.i_dut_out == '0;
  assign cnt_inc  = cnt_q + 1'b1;
  assign {o_drive_delayed_a, o_drive_delayed_b, o_probe_delayed} = dly_q[DELAY_DEPTH-1];
  assign o_dut_delay      = dut_delay_q;
  assign o_delay_valid    = valid_q;
  assign o_delay_unstable = unstable_q;
  assign o_timeout        = timeout_q;
  // shift the values actually driven, not the raw random inputs, down the monitor alignment line
  always_comb begin
    dly_d[0] = {drive_a, drive_b, probe};
    for (int i = 1; i < DELAY_DEPTH; i++) dly_d[i] = dly_q[i-1];
  end
  // measurement FSM: a zero result wins over the timeout check on the same edge
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap       = 1'b0;
    cap_v     = cnt_inc;
    timeout_d = timeout_q;
    case (state_q)
      FLUSH: state_d = dut_zero ? ARMED : FLUSH;
      ARMED: if (probe) begin
        cap     = dut_zero;
        cap_v   = '0;
        cnt_d   = '0;
        state_d = dut_zero ? ARMED : COUNT;
      end
      COUNT: begin
        if (dut_zero) begin
          cap     = 1'b1;
          state_d = ARMED;
        end else if (cnt_inc == CNT_WIDTH'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = ARMED;
        end else cnt_d = cnt_inc;
      end
      default: state_d = FLUSH;
    endcase
    dut_delay_d = cap ? cap_v : dut_delay_q;
    valid_d     = valid_q | cap;
    unstable_d  = unstable_q | (cap & valid_q & (cap_v != dut_delay_q));
  end
  // state registers; sticky flags only clear on reset
  always_ff @(posedge clk_dut or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FLUSH;
      period_q    <= '0;
      cnt_q       <= '0;
      dut_delay_q <= '1;
      valid_q     <= 1'b0;
      unstable_q  <= 1'b0;
      timeout_q   <= 1'b0;
      for (int i = 0; i < DELAY_DEPTH; i++) dly_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      dut_delay_q <= dut_delay_d;
      valid_q     <= valid_d;
      unstable_q  <= unstable_d;
      timeout_q   <= timeout_d;
      for (int i = 0; i < DELAY_DEPTH; i++) dly_q[i] <= dly_d[i];
    end
  end
endmodule

// File: tb/tb_stim_driver.sv
// tb_stim_driver: scoreboard bench for stim_driver against a registered-adder DUT model
module tb_stim_driver;
  typedef struct packed {logic [31:0] a; logic [31:0] b; logic p;} drv_t;
  logic        clk_dut = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_probe_en = 1'b1;
  logic [31:0] o_drive_delayed_a, o_drive_delayed_b;
  logic        o_probe_delayed, o_delay_valid, o_delay_unstable, o_timeout;
  logic [7:0]  o_dut_delay;
  int          lat = 3;
  logic        force_ff = 1'b0;
  logic [31:0] pipe [8] = '{default: 32'd1};
  int          vectors = 0, errors = 0, cyc = 0;
  logic        exp_probe;
  logic [31:0] exp_a, exp_b;
  drv_t        sb [$];
  stim_driver_if #(.WIDTH(32)) bus ();
  stim_driver #(.WIDTH(32), .DELAY_DEPTH(3), .PERIOD_BITS(4), .CNT_WIDTH(8), .TIMEOUT(12)) dut (
    .clk_dut(clk_dut), .reset_n(reset_n), .i_probe_en(i_probe_en), .bus(bus.master),
    .o_drive_delayed_a(o_drive_delayed_a), .o_drive_delayed_b(o_drive_delayed_b),
    .o_probe_delayed(o_probe_delayed), .o_dut_delay(o_dut_delay), .o_delay_valid(o_delay_valid),
    .o_delay_unstable(o_delay_unstable), .o_timeout(o_timeout)
  );
  always #5 clk_dut = ~clk_dut;
  // registered adder model with selectable latency; lat 0 is purely combinational
  always @(posedge clk_dut) begin
    pipe[0] <= bus.o_drive_a + bus.o_drive_b;
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.i_dut_out = force_ff ? 32'hFFFF_FFFF :
                         (lat == 0 ? bus.o_drive_a + bus.o_drive_b : pipe[3'(lat - 1)]);
  // odd a plus even b never sums to zero, so only probes produce a zero result
  task tick;
    @(posedge clk_dut);
    #1;
    if (reset_n) cyc++;
    bus.i_rand_a = $urandom | 32'd1;
    bus.i_rand_b = $urandom & ~32'd1;
    exp_probe = (cyc % 16 == 15) && i_probe_en;
    exp_a = exp_probe ? 32'd0 : bus.i_rand_a;
    exp_b = exp_probe ? 32'd0 : bus.i_rand_b;
    sb.push_back('{exp_a, exp_b, exp_probe});
    #1;
  endtask
  task tick_to(input int n);
    for (int i = 0; i < 2000 && cyc < n; i++) tick();
  endtask
  task test_reset;
    bus.i_rand_a = 32'h1; bus.i_rand_b = 32'h2;
    repeat (3) tick();
    reset_n = 1'b1; cyc = 0;
    tick_to(32);
    reset_n = 1'b0; cyc = 0;
    repeat (4) tick();
    vectors++; if (o_drive_delayed_a !== 32'd0 || o_drive_delayed_b !== 32'd0 || o_probe_delayed !== 1'b0) begin errors++; $display("FAIL rst_delayed: got %h %h %b want 0 0 0", o_drive_delayed_a, o_drive_delayed_b, o_probe_delayed); end
    vectors++; if (o_dut_delay !== 8'hFF || o_delay_valid !== 1'b0 || o_delay_unstable !== 1'b0 || o_timeout !== 1'b0) begin errors++; $display("FAIL rst_meas: got %h %b %b %b want ff 0 0 0", o_dut_delay, o_delay_valid, o_delay_unstable, o_timeout); end
    vectors++; if (bus.o_probe !== 1'b0 || bus.o_drive_a !== bus.i_rand_a || bus.o_drive_b !== bus.i_rand_b) begin errors++; $display("FAIL rst_drive: got %b %h %h want 0 %h %h", bus.o_probe, bus.o_drive_a, bus.o_drive_b, bus.i_rand_a, bus.i_rand_b); end
    reset_n = 1'b1;
    for (int i = 1; i < 15; i++) begin
      tick();
      vectors++; if (bus.o_probe !== 1'b0) begin errors++; $display("FAIL early_probe cyc %0d: got %b want 0", cyc, bus.o_probe); end
    end
    tick();
    vectors++; if (bus.o_probe !== 1'b1 || bus.o_drive_a !== 32'd0 || bus.o_drive_b !== 32'd0) begin errors++; $display("FAIL first_probe: got %b %h %h want 1 0 0", bus.o_probe, bus.o_drive_a, bus.o_drive_b); end
  endtask
  task test_steady;
    tick_to(34);
    vectors++; if (o_delay_valid !== 1'b0 || o_dut_delay !== 8'hFF) begin errors++; $display("FAIL pre_capture: got %b %h want 0 ff", o_delay_valid, o_dut_delay); end
    tick_to(35);
    vectors++; if (o_dut_delay !== 8'd3 || o_delay_valid !== 1'b1) begin errors++; $display("FAIL first_capture: got %0d %b want 3 1", o_dut_delay, o_delay_valid); end
    for (int k = 2; k < 22; k++) begin
      tick_to(15 + 16 * k + 4);
      vectors++; if (o_dut_delay !== 8'd3 || o_delay_unstable !== 1'b0) begin errors++; $display("FAIL steady probe %0d: got %0d %b want 3 0", k, o_dut_delay, o_delay_unstable); end
    end
  endtask
  task test_change;
    lat = 5;
    tick_to(373);
    vectors++; if (o_dut_delay !== 8'd5 || o_delay_unstable !== 1'b1) begin errors++; $display("FAIL lat5: got %0d %b want 5 1", o_dut_delay, o_delay_unstable); end
    lat = 3;
    tick_to(387);
    vectors++; if (o_dut_delay !== 8'd3 || o_delay_unstable !== 1'b1) begin errors++; $display("FAIL lat3_back: got %0d %b want 3 1", o_dut_delay, o_delay_unstable); end
  endtask
  task test_timeout;
    force_ff = 1'b1;
    tick_to(411);
    vectors++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", o_timeout); end
    tick_to(412);
    vectors++; if (o_timeout !== 1'b1 || o_dut_delay !== 8'd3) begin errors++; $display("FAIL timeout_set: got %b %0d want 1 3", o_timeout, o_dut_delay); end
    force_ff = 1'b0;
    tick_to(419);
    vectors++; if (o_dut_delay !== 8'd3 || o_timeout !== 1'b1 || o_delay_valid !== 1'b1) begin errors++; $display("FAIL post_timeout: got %0d %b %b want 3 1 1", o_dut_delay, o_timeout, o_delay_valid); end
  endtask
  task test_comb;
    reset_n = 1'b0; cyc = 0; lat = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick_to(31);
    vectors++; if (o_delay_valid !== 1'b0 || o_timeout !== 1'b0) begin errors++; $display("FAIL comb_pre: got %b %b want 0 0", o_delay_valid, o_timeout); end
    tick_to(32);
    vectors++; if (o_dut_delay !== 8'd0 || o_delay_valid !== 1'b1 || o_delay_unstable !== 1'b0) begin errors++; $display("FAIL comb_capture: got %0d %b %b want 0 1 0", o_dut_delay, o_delay_valid, o_delay_unstable); end
  endtask
  task test_align;
    drv_t e;
    int probes;
    probes = 0;
    sb.delete();
    repeat (3) tick();
    for (int i = 0; i < 100; i++) begin
      tick();
      e = sb.pop_front();
      probes += int'(e.p);
      vectors++; if (o_drive_delayed_a !== e.a || o_drive_delayed_b !== e.b || o_probe_delayed !== e.p) begin errors++; $display("FAIL align cyc %0d: got %h %h %b want %h %h %b", cyc, o_drive_delayed_a, o_drive_delayed_b, o_probe_delayed, e.a, e.b, e.p); end
      vectors++; if (bus.o_drive_a !== exp_a || bus.o_probe !== exp_probe) begin errors++; $display("FAIL drive cyc %0d: got %h %b want %h %b", cyc, bus.o_drive_a, bus.o_probe, exp_a, exp_probe); end
    end
    vectors++; if (probes < 6) begin errors++; $display("FAIL align_probes: got %0d want >=6", probes); end
  endtask
  task test_gating;
    i_probe_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      vectors++; if (bus.o_probe !== 1'b0 || bus.o_drive_a !== bus.i_rand_a) begin errors++; $display("FAIL gating cyc %0d: got %b %h want 0 %h", cyc, bus.o_probe, bus.o_drive_a, bus.i_rand_a); end
    end
  endtask
  initial begin
    test_reset();
    test_steady();
    test_change();
    test_timeout();
    test_comb();
    test_align();
    test_gating();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
